// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM stage with data RAM, configurable wait states and MEM/WB register
//
// Purpose:
//   Performs the load/store to a word-addressed synchronous data RAM and holds
//   the MEM/WB pipeline register. With MEM_LATENCY > 0 each access occupies
//   MEM_LATENCY extra cycles, during which stall is raised and a bubble is
//   written into MEM/WB.
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN
//   Defined   : misaligned accesses (ALUresult[1:0] != 0) are suppressed
//               (no store, no load data, RegWrite cleared) and flagged on misalign.
//   Undefined : ALUresult[1:0] are ignored and misalign is held at 0.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous reset, active-high
//   WBreg        in   [1]=RegWrite, [0]=MemtoReg
//   Mreg         in   [1]=MemWrite, [0]=MemRead
//   ALUresult    in   byte address for loads/stores, passthrough otherwise
//   writedata    in   store data
//   writeReg     in   destination register
//   stall        out  access still in flight, upstream must hold EX/MEM
//   WBregOut     out  registered WBreg (bubble = 0)
//   readdataOut  out  registered load data
//   ALUresultOut out  registered ALUresult
//   writeRegOut  out  registered writeReg
//   misalign     out  registered misaligned-access flag

module mem_wb_stage #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int MEM_LATENCY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        WBreg,
  input  logic [1:0]        Mreg,
  input  logic [DATA_W-1:0] ALUresult,
  input  logic [DATA_W-1:0] writedata,
  input  logic [4:0]        writeReg,
  output logic              stall,
  output logic [1:0]        WBregOut,
  output logic [DATA_W-1:0] readdataOut,
  output logic [DATA_W-1:0] ALUresultOut,
  output logic [4:0]        writeRegOut,
  output logic              misalign
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (MEM_LATENCY > 0) ? CNT_W'(MEM_LATENCY - 1) : '0;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              complete;
  logic              access;
  logic              mis;
  logic              do_store;
  logic              do_load;
  logic [ADDR_W-1:0] idx;

  logic [DATA_W-1:0] ram [2**ADDR_W];

  // Upper address bits wrap silently; the byte-offset bits only matter with the trap enabled.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ALUresult[DATA_W-1:ADDR_W+2], ALUresult[1:0]};

  assign idx    = ALUresult[ADDR_W+1:2];
  assign access = Mreg[1] | Mreg[0];

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = access & (ALUresult[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  // A store wins when both MemWrite and MemRead are set; load data is then zero.
  assign do_store = Mreg[1] & ~mis;
  assign do_load  = Mreg[0] & ~Mreg[1] & ~mis;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall      = 1'b0;
    complete   = 1'b0;
    case (state)
      S_IDLE: begin
        if (access && (MEM_LATENCY > 0)) begin
          stall      = 1'b1;
          cnt_next   = CNT_LOAD;
          state_next = S_WAIT;
        end else begin
          complete = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt != '0) begin
          stall    = 1'b1;
          cnt_next = cnt - CNT_W'(1);
        end else begin
          complete   = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      WBregOut     <= '0;
      readdataOut  <= '0;
      ALUresultOut <= '0;
      writeRegOut  <= '0;
      misalign     <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (complete) begin
        WBregOut     <= {WBreg[1] & ~mis, WBreg[0]};
        readdataOut  <= do_load ? ram[idx] : '0;
        ALUresultOut <= ALUresult;
        writeRegOut  <= writeReg;
        misalign     <= mis;
      end else begin
        // Bubble while the access is still waiting.
        WBregOut     <= '0;
        readdataOut  <= '0;
        ALUresultOut <= '0;
        writeRegOut  <= '0;
        misalign     <= 1'b0;
      end
    end
  end

  // RAM contents survive reset; a reset on the completion edge drops the store.
  always_ff @(posedge clk) begin
    if (!rst && complete && do_store) begin
      ram[idx] <= writedata;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage at latencies 0, 2 and 3

module tb_mem_wb_stage;

  logic        clk;
  logic        rst  [3];
  logic [1:0]  wb   [3];
  logic [1:0]  mr   [3];
  logic [31:0] alu  [3];
  logic [31:0] wd   [3];
  logic [4:0]  wr   [3];
  logic        st_o [3];
  logic [1:0]  wb_o [3];
  logic [31:0] rd_o [3];
  logic [31:0] al_o [3];
  logic [4:0]  wr_o [3];
  logic        mi_o [3];

  int n_cmp  = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(32), .ADDR_W(8), .MEM_LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst[0]), .WBreg(wb[0]), .Mreg(mr[0]), .ALUresult(alu[0]),
    .writedata(wd[0]), .writeReg(wr[0]), .stall(st_o[0]), .WBregOut(wb_o[0]),
    .readdataOut(rd_o[0]), .ALUresultOut(al_o[0]), .writeRegOut(wr_o[0]), .misalign(mi_o[0]));

  mem_wb_stage #(.DATA_W(32), .ADDR_W(8), .MEM_LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst[1]), .WBreg(wb[1]), .Mreg(mr[1]), .ALUresult(alu[1]),
    .writedata(wd[1]), .writeReg(wr[1]), .stall(st_o[1]), .WBregOut(wb_o[1]),
    .readdataOut(rd_o[1]), .ALUresultOut(al_o[1]), .writeRegOut(wr_o[1]), .misalign(mi_o[1]));

  mem_wb_stage #(.DATA_W(32), .ADDR_W(8), .MEM_LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst[2]), .WBreg(wb[2]), .Mreg(mr[2]), .ALUresult(alu[2]),
    .writedata(wd[2]), .writeReg(wr[2]), .stall(st_o[2]), .WBregOut(wb_o[2]),
    .readdataOut(rd_o[2]), .ALUresultOut(al_o[2]), .writeRegOut(wr_o[2]), .misalign(mi_o[2]));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic [1:0] w, input logic [1:0] m,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
    wb[k] = w; mr[k] = m; alu[k] = a; wd[k] = d; wr[k] = r;
    #1;
  endtask

  task automatic test_reset;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1;
      wb[k] = 2'b11; mr[k] = 2'b00; alu[k] = 32'h5; wd[k] = 32'h0; wr[k] = 5'd7;
    end
    tick;
    tick;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (st_o[k] !== 1'b0)     begin n_fail++; $display("FAIL reset_stall[%0d] got %b exp 0", k, st_o[k]); end
      n_cmp++; if (wb_o[k] !== 2'b00)    begin n_fail++; $display("FAIL reset_wb[%0d] got %b exp 00", k, wb_o[k]); end
      n_cmp++; if (rd_o[k] !== 32'h0)    begin n_fail++; $display("FAIL reset_rd[%0d] got %h exp 0", k, rd_o[k]); end
      n_cmp++; if (al_o[k] !== 32'h0)    begin n_fail++; $display("FAIL reset_alu[%0d] got %h exp 0", k, al_o[k]); end
      n_cmp++; if (wr_o[k] !== 5'd0)     begin n_fail++; $display("FAIL reset_wr[%0d] got %0d exp 0", k, wr_o[k]); end
      n_cmp++; if (mi_o[k] !== 1'b0)     begin n_fail++; $display("FAIL reset_mis[%0d] got %b exp 0", k, mi_o[k]); end
    end
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0;
      wb[k] = 2'b00; mr[k] = 2'b00; alu[k] = 32'h0; wr[k] = 5'd0;
    end
  endtask

  task automatic test_lat0_round_trip;
    drive(0, 2'b00, 2'b10, 32'h40, 32'hDEADBEEF, 5'd0);
    n_cmp++; if (st_o[0] !== 1'b0) begin n_fail++; $display("FAIL lat0_store_stall got %b exp 0", st_o[0]); end
    tick;
    n_cmp++; if (rd_o[0] !== 32'h0) begin n_fail++; $display("FAIL lat0_store_rd got %h exp 0", rd_o[0]); end
    drive(0, 2'b11, 2'b01, 32'h40, 32'h0, 5'd8);
    n_cmp++; if (st_o[0] !== 1'b0) begin n_fail++; $display("FAIL lat0_load_stall got %b exp 0", st_o[0]); end
    tick;
    n_cmp++; if (rd_o[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lat0_load_rd got %h exp deadbeef", rd_o[0]); end
    n_cmp++; if (wb_o[0] !== 2'b11)        begin n_fail++; $display("FAIL lat0_load_wb got %b exp 11", wb_o[0]); end
    n_cmp++; if (wr_o[0] !== 5'd8)         begin n_fail++; $display("FAIL lat0_load_wr got %0d exp 8", wr_o[0]); end
    n_cmp++; if (al_o[0] !== 32'h40)       begin n_fail++; $display("FAIL lat0_load_alu got %h exp 40", al_o[0]); end
    // 0x440 maps to the same word as 0x40 with 256 words
    drive(0, 2'b11, 2'b01, 32'h440, 32'h0, 5'd9);
    tick;
    n_cmp++; if (rd_o[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lat0_wrap_rd got %h exp deadbeef", rd_o[0]); end
    // both MemRead and MemWrite: store performed, load data zero
    drive(0, 2'b11, 2'b11, 32'h44, 32'h00C0FFEE, 5'd4);
    tick;
    n_cmp++; if (rd_o[0] !== 32'h0) begin n_fail++; $display("FAIL lat0_both_rd got %h exp 0", rd_o[0]); end
    drive(0, 2'b11, 2'b01, 32'h44, 32'h0, 5'd4);
    tick;
    n_cmp++; if (rd_o[0] !== 32'h00C0FFEE) begin n_fail++; $display("FAIL lat0_both_store got %h exp 00c0ffee", rd_o[0]); end
  endtask

  task automatic test_misalign;
    logic        exp_mis;
    logic [1:0]  exp_wb;
    logic [31:0] exp_rd;
`ifdef MEM_MISALIGN_TRAP_EN
    exp_mis = 1'b1; exp_wb = 2'b00; exp_rd = 32'hDEADBEEF;
`else
    exp_mis = 1'b0; exp_wb = 2'b10; exp_rd = 32'hCAFEF00D;
`endif
    drive(0, 2'b10, 2'b10, 32'h43, 32'hCAFEF00D, 5'd2);
    tick;
    n_cmp++; if (mi_o[0] !== exp_mis) begin n_fail++; $display("FAIL mis_flag got %b exp %b", mi_o[0], exp_mis); end
    n_cmp++; if (wb_o[0] !== exp_wb)  begin n_fail++; $display("FAIL mis_wb got %b exp %b", wb_o[0], exp_wb); end
    drive(0, 2'b11, 2'b01, 32'h40, 32'h0, 5'd8);
    tick;
    n_cmp++; if (mi_o[0] !== 1'b0)   begin n_fail++; $display("FAIL mis_pulse got %b exp 0", mi_o[0]); end
    n_cmp++; if (rd_o[0] !== exp_rd) begin n_fail++; $display("FAIL mis_load_rd got %h exp %h", rd_o[0], exp_rd); end
    drive(0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic test_lat2_load;
    drive(1, 2'b00, 2'b10, 32'h40, 32'hDEADBEEF, 5'd0);
    tick; tick; tick;
    drive(1, 2'b11, 2'b01, 32'h40, 32'h0, 5'd8);
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (st_o[1] !== 1'b1) begin n_fail++; $display("FAIL lat2_stall_c%0d got %b exp 1", i, st_o[1]); end
      tick;
      n_cmp++; if (wb_o[1] !== 2'b00) begin n_fail++; $display("FAIL lat2_bubble_c%0d got %b exp 00", i, wb_o[1]); end
    end
    n_cmp++; if (st_o[1] !== 1'b0) begin n_fail++; $display("FAIL lat2_stall_end got %b exp 0", st_o[1]); end
    tick;
    n_cmp++; if (rd_o[1] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lat2_load_rd got %h exp deadbeef", rd_o[1]); end
    n_cmp++; if (wb_o[1] !== 2'b11)        begin n_fail++; $display("FAIL lat2_load_wb got %b exp 11", wb_o[1]); end
    n_cmp++; if (wr_o[1] !== 5'd8)         begin n_fail++; $display("FAIL lat2_load_wr got %0d exp 8", wr_o[1]); end
  endtask

  task automatic test_back_to_back;
    // next access immediately after completion: stall must rise in the very next cycle
    drive(1, 2'b11, 2'b01, 32'h40, 32'h0, 5'd6);
    n_cmp++; if (st_o[1] !== 1'b1) begin n_fail++; $display("FAIL b2b_stall got %b exp 1", st_o[1]); end
    tick; tick; tick;
    n_cmp++; if (rd_o[1] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_rd got %h exp deadbeef", rd_o[1]); end
    n_cmp++; if (wr_o[1] !== 5'd6)         begin n_fail++; $display("FAIL b2b_wr got %0d exp 6", wr_o[1]); end
    drive(1, 2'b10, 2'b00, 32'h99, 32'h0, 5'd1);
    n_cmp++; if (st_o[1] !== 1'b0) begin n_fail++; $display("FAIL b2b_alu_stall got %b exp 0", st_o[1]); end
    tick;
    n_cmp++; if (al_o[1] !== 32'h99) begin n_fail++; $display("FAIL b2b_alu got %h exp 99", al_o[1]); end
    drive(1, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic test_lat3_alu_only;
    drive(2, 2'b10, 2'b00, 32'h1234, 32'h0, 5'd5);
    n_cmp++; if (st_o[2] !== 1'b0) begin n_fail++; $display("FAIL lat3_alu_stall got %b exp 0", st_o[2]); end
    tick;
    n_cmp++; if (al_o[2] !== 32'h1234) begin n_fail++; $display("FAIL lat3_alu_out got %h exp 1234", al_o[2]); end
    n_cmp++; if (rd_o[2] !== 32'h0)    begin n_fail++; $display("FAIL lat3_alu_rd got %h exp 0", rd_o[2]); end
    n_cmp++; if (wb_o[2] !== 2'b10)    begin n_fail++; $display("FAIL lat3_alu_wb got %b exp 10", wb_o[2]); end
  endtask

  task automatic test_lat3_reset_mid_store;
    drive(2, 2'b00, 2'b10, 32'h80, 32'h11, 5'd0);
    tick; tick; tick; tick;
    drive(2, 2'b00, 2'b10, 32'h80, 32'h55, 5'd0);
    tick;
    n_cmp++; if (st_o[2] !== 1'b1) begin n_fail++; $display("FAIL lat3_rst_stall2 got %b exp 1", st_o[2]); end
    rst[2] = 1'b1;
    tick;
    rst[2] = 1'b0;
    drive(2, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    n_cmp++; if (st_o[2] !== 1'b0)  begin n_fail++; $display("FAIL lat3_rst_stall got %b exp 0", st_o[2]); end
    n_cmp++; if (wb_o[2] !== 2'b00) begin n_fail++; $display("FAIL lat3_rst_wb got %b exp 00", wb_o[2]); end
    n_cmp++; if (al_o[2] !== 32'h0) begin n_fail++; $display("FAIL lat3_rst_alu got %h exp 0", al_o[2]); end
    drive(2, 2'b11, 2'b01, 32'h80, 32'h0, 5'd3);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (st_o[2] !== 1'b1) begin n_fail++; $display("FAIL lat3_load_stall_c%0d got %b exp 1", i, st_o[2]); end
      tick;
    end
    n_cmp++; if (st_o[2] !== 1'b0) begin n_fail++; $display("FAIL lat3_load_stall_end got %b exp 0", st_o[2]); end
    tick;
    n_cmp++; if (rd_o[2] !== 32'h11) begin n_fail++; $display("FAIL lat3_load_rd got %h exp 11", rd_o[2]); end
    n_cmp++; if (wr_o[2] !== 5'd3)   begin n_fail++; $display("FAIL lat3_load_wr got %0d exp 3", wr_o[2]); end
  endtask

  initial begin
    test_reset;
    test_lat0_round_trip;
    test_misalign;
    test_lat2_load;
    test_back_to_back;
    test_lat3_alu_only;
    test_lat3_reset_mid_store;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
